// File: rtl/flash_sample_streamer_if.sv
// Read-request channel between the sample streamer (master) and the SPI flash reader (slave).
// One request is outstanding at a time; flash_ready is a one-cycle completion pulse.
interface flash_sample_streamer_if;
  logic [23:0] flash_addr;
  logic        flash_valid;
  logic [31:0] flash_rdata;
  logic        flash_ready;

  modport master (output flash_addr, flash_valid, input  flash_rdata, flash_ready);
  modport slave  (input  flash_addr, flash_valid, output flash_rdata, flash_ready);
endinterface

// File: rtl/flash_sample_streamer.sv
// Fetches 32-bit words over a looping flash window, unpacks them into a 16-bit sample FIFO
// and releases one sample per sample_tick_i, counting underruns.
module flash_sample_streamer #(
  parameter int FIFO_AW = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  input  logic [23:0]            base_addr_i,
  input  logic [23:0]            len_words_i,
  input  logic                   sample_tick_i,
  flash_sample_streamer_if.master flash,
  output logic [15:0]            sample_out_o,
  output logic                   sample_valid_o,
  output logic [7:0]             underruns_o,
  output logic [FIFO_AW:0]       fifo_level_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FETCH_THR = (FIFO_AW+1)'(DEPTH - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_PUSH_HI = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [23:0]        idx_q, idx_d, len_q, len_d, addr_q, addr_d;
  logic               fvalid_q, fvalid_d, abort_q, abort_d;
  logic [15:0]        hi_q, hi_d, out_q, out_d;
  logic               svalid_q;
  logic [7:0]         urun_q, urun_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]        mem [DEPTH];
  logic               push, pop, flush;
  logic [15:0]        push_data;
  logic [23:0]        eff_len;

  assign eff_len = (len_q == 24'd0) ? 24'd1 : len_q;
  assign pop     = enable_i && sample_tick_i && (level_q != '0);

  // abort_q remembers a disable seen mid-fetch so the completing word is dropped
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    addr_d    = addr_q;
    fvalid_d  = fvalid_q;
    hi_d      = hi_q;
    abort_d   = abort_q;
    push      = 1'b0;
    push_data = flash.flash_rdata[15:0];
    flush     = 1'b0;
    if (state_q != S_IDLE && !enable_i) abort_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (!enable_i) begin
          flush = 1'b1;
          idx_d = '0;
        end else if (level_q <= FETCH_THR) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        addr_d   = (base_addr_i & ~24'h3) + (idx_q << 2);
        len_d    = len_words_i;
        fvalid_d = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (flash.flash_ready) begin
          fvalid_d = 1'b0;
          hi_d     = flash.flash_rdata[31:16];
          push     = !abort_d;
          state_d  = S_PUSH_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (abort_d) begin
          flush = 1'b1;
          idx_d = '0;
        end else begin
          push      = 1'b1;
          push_data = hi_q;
          idx_d     = (idx_q >= eff_len - 24'd1) ? 24'd0 : idx_q + 24'd1;
        end
      end
    endcase
  end

  // pop reads the registered head, so a push into an empty FIFO cannot be popped that cycle
  always_comb begin
    out_d   = out_q;
    urun_d  = urun_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    if (enable_i && sample_tick_i && level_q == '0 && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
    if (pop) begin
      out_d  = mem[rptr_q];
      rptr_d = rptr_q + 1'b1;
    end
    if (push) wptr_d = wptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end
    if (state_q == S_IDLE && !enable_i) out_d = '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      fvalid_q <= 1'b0;
      hi_q     <= '0;
      abort_q  <= 1'b0;
      out_q    <= '0;
      svalid_q <= 1'b0;
      urun_q   <= '0;
      level_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      fvalid_q <= fvalid_d;
      hi_q     <= hi_d;
      abort_q  <= abort_d;
      out_q    <= out_d;
      svalid_q <= pop;
      urun_q   <= urun_d;
      level_q  <= level_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  assign flash.flash_addr  = addr_q;
  assign flash.flash_valid = fvalid_q;
  assign sample_out_o      = out_q;
  assign sample_valid_o    = svalid_q;
  assign underruns_o       = urun_q;
  assign fifo_level_o      = level_q;
endmodule
